addsub_arbiter: RTL and testbench

ADDSUB_ARBITER -- requirements
Module: addsub_arbiter

---
 rtl/addsub_arb_pkg.sv | 13 +
 rtl/addsub_arbiter_if.sv | 40 ++++
 rtl/addsub_core.sv | 26 ++
 rtl/addsub_arbiter.sv | 124 ++++++++++++
 tb/tb_addsub_arbiter.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/addsub_arb_pkg.sv
// Shared definitions for the two-requester add/subtract arbiter: default
// datapath width and the FSM state encoding.
package addsub_arb_pkg;

  localparam int WIDTH_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HOLD = 2'd2
  } state_e;

endpackage

// File: rtl/addsub_arbiter_if.sv
// Bundle of the two request channels and the response channel; the master
// side is the requesters plus the result consumer, the slave side is the arbiter.
interface addsub_arbiter_if #(
  parameter int WIDTH = addsub_arb_pkg::WIDTH_DEFAULT
);

  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic             req0_sub;
  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic             req1_sub;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_sum;
  logic             rsp_cout;
  logic             rsp_ovf;

  modport master (
    output req0_valid, req0_a, req0_b, req0_sub,
    output req1_valid, req1_a, req1_b, req1_sub,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_ovf
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_sub,
    input  req1_valid, req1_a, req1_b, req1_sub,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_ovf
  );

endinterface

// File: rtl/addsub_core.sv
// Combinational WIDTH-bit adder/subtractor producing sum, carry out of the
// MSB (1 = no borrow when subtracting) and signed overflow.
module addsub_core #(
  parameter int WIDTH = addsub_arb_pkg::WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   full;

  always_comb begin
    // Subtraction as a + ~b + 1, so one adder serves both operations.
    b_eff = sub ? ~b : b;
    full  = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
    sum   = full[WIDTH-1:0];
    cout  = full[WIDTH];
    ovf   = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
  end

endmodule

// File: rtl/addsub_arbiter.sv
// Two-requester round-robin arbiter in front of a shared add/subtract unit;
// one operation in flight, IDLE -> EXEC -> HOLD per operation.
module addsub_arbiter
  import addsub_arb_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_sub,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_sub,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_cout,
  output logic             rsp_ovf
);

  state_e           state_q, state_d;
  logic             ptr_q, ptr_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             sub_q, sub_d, id_q, id_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d, ovf_q, ovf_d, rid_q, rid_d;
  logic             gnt0, gnt1;
  logic [WIDTH-1:0] core_sum;
  logic             core_cout, core_ovf;

  addsub_core #(.WIDTH(WIDTH)) u_core (
    .a    (a_q),
    .b    (b_q),
    .sub  (sub_q),
    .sum  (core_sum),
    .cout (core_cout),
    .ovf  (core_ovf)
  );

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    ptr_d   = ptr_q;
    a_d     = a_q;
    b_d     = b_q;
    sub_d   = sub_q;
    id_d    = id_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    rid_d   = rid_q;
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    case (state_q)
      IDLE: begin
        // ptr_q = 0 favours requester 0 on a tie, 1 favours requester 1.
        gnt0 = req0_valid & (~req1_valid | ~ptr_q);
        gnt1 = req1_valid & (~req0_valid |  ptr_q);
        if (gnt0 | gnt1) begin
          state_d = EXEC;
          ptr_d   = gnt0;
          id_d    = gnt1;
          a_d     = gnt1 ? req1_a   : req0_a;
          b_d     = gnt1 ? req1_b   : req0_b;
          sub_d   = gnt1 ? req1_sub : req0_sub;
        end
      end
      EXEC: begin
        state_d = HOLD;
        sum_d   = core_sum;
        cout_d  = core_cout;
        ovf_d   = core_ovf;
        rid_d   = id_q;
      end
      HOLD: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sub_q   <= 1'b0;
      id_q    <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      rid_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sub_q   <= sub_d;
      id_q    <= id_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      rid_q   <= rid_d;
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign rsp_valid  = (state_q == HOLD);
  assign rsp_id     = rid_q;
  assign rsp_sum    = sum_q;
  assign rsp_cout   = cout_q;
  assign rsp_ovf    = ovf_q;

endmodule

// File: tb/tb_addsub_arbiter.sv
// Directed self-checking bench for addsub_arbiter: arithmetic corners,
// round-robin order, response back-pressure and reset mid-operation.
module tb_addsub_arbiter;

  localparam int W = 32;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  addsub_arbiter_if #(.WIDTH(W)) bus ();

  addsub_arbiter #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (bus.req0_valid),
    .req0_ready (bus.req0_ready),
    .req0_a     (bus.req0_a),
    .req0_b     (bus.req0_b),
    .req0_sub   (bus.req0_sub),
    .req1_valid (bus.req1_valid),
    .req1_ready (bus.req1_ready),
    .req1_a     (bus.req1_a),
    .req1_b     (bus.req1_b),
    .req1_sub   (bus.req1_sub),
    .rsp_valid  (bus.rsp_valid),
    .rsp_ready  (bus.rsp_ready),
    .rsp_id     (bus.rsp_id),
    .rsp_sum    (bus.rsp_sum),
    .rsp_cout   (bus.rsp_cout),
    .rsp_ovf    (bus.rsp_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One operation from a lone requester with rsp_ready high; called one
  // settle step after a rising edge with the arbiter in IDLE.
  task automatic run_op(input string tag, input logic rid, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic sub, input logic [W-1:0] es,
                        input logic ec, input logic eo);
    if (rid) begin
      bus.req1_valid = 1'b1; bus.req1_a = a; bus.req1_b = b; bus.req1_sub = sub;
    end else begin
      bus.req0_valid = 1'b1; bus.req0_a = a; bus.req0_b = b; bus.req0_sub = sub;
    end
    #1;
    check({tag, ".ready0"}, 64'(bus.req0_ready), 64'(!rid));
    check({tag, ".ready1"}, 64'(bus.req1_ready), 64'(rid));
    tick();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    check({tag, ".exec_valid"}, 64'(bus.rsp_valid), 64'(0));
    check({tag, ".exec_rdy"}, 64'({bus.req0_ready, bus.req1_ready}), 64'(0));
    tick();
    check({tag, ".valid"}, 64'(bus.rsp_valid), 64'(1));
    check({tag, ".sum"}, 64'(bus.rsp_sum), 64'(es));
    check({tag, ".cout"}, 64'(bus.rsp_cout), 64'(ec));
    check({tag, ".ovf"}, 64'(bus.rsp_ovf), 64'(eo));
    check({tag, ".id"}, 64'(bus.rsp_id), 64'(rid));
    tick();
    check({tag, ".done"}, 64'(bus.rsp_valid), 64'(0));
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    bus.rsp_ready  = 1'b1;
    bus.req0_valid = 1'b1; bus.req0_a = 32'h11;  bus.req0_b = 32'h22; bus.req0_sub = 1'b0;
    bus.req1_valid = 1'b1; bus.req1_a = 32'h100; bus.req1_b = 32'h1;  bus.req1_sub = 1'b1;
    #3;
    check("rst.valid", 64'(bus.rsp_valid), 64'(0));
    check("rst.sum",   64'(bus.rsp_sum),   64'(0));
    check("rst.id",    64'(bus.rsp_id),    64'(0));
    check("rst.flags", 64'({bus.rsp_cout, bus.rsp_ovf}), 64'(0));
    tick();
    tick();
    check("rst.held", 64'(bus.rsp_valid), 64'(0));
    rst_n = 1'b1;

    // Both requesters valid from reset: grants alternate 0,1,0,1.
    for (int k = 0; k < 4; k++) begin
      #1;
      check("rr.ready0", 64'(bus.req0_ready), 64'(k % 2 == 0));
      check("rr.ready1", 64'(bus.req1_ready), 64'(k % 2 == 1));
      tick();
      check("rr.exec_valid", 64'(bus.rsp_valid), 64'(0));
      tick();
      check("rr.valid", 64'(bus.rsp_valid), 64'(1));
      check("rr.id",    64'(bus.rsp_id),    64'(k % 2));
      check("rr.sum",   64'(bus.rsp_sum),   (k % 2 == 0) ? 64'h33 : 64'hFF);
      check("rr.cout",  64'(bus.rsp_cout),  64'(k % 2));
      tick();
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    #1;
    check("rr.idle", 64'(bus.rsp_valid), 64'(0));

    run_op("add5p3",  1'b0, 32'h5,        32'h3, 1'b0, 32'h8,        1'b0, 1'b0);
    run_op("sub5m3",  1'b1, 32'h5,        32'h3, 1'b1, 32'h2,        1'b1, 1'b0);
    run_op("sub3m5",  1'b1, 32'h3,        32'h5, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0);
    run_op("addovf",  1'b0, 32'h7FFFFFFF, 32'h1, 1'b0, 32'h80000000, 1'b0, 1'b1);
    run_op("addwrap", 1'b0, 32'hFFFFFFFF, 32'h1, 1'b0, 32'h00000000, 1'b1, 1'b0);
    run_op("subovf",  1'b1, 32'h80000000, 32'h1, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1);

    // Back-pressure: result held for 5 cycles while req1 waits.
    bus.rsp_ready  = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_a = 32'h10; bus.req0_b = 32'h20; bus.req0_sub = 1'b0;
    #1;
    check("bp.ready0", 64'(bus.req0_ready), 64'(1));
    tick();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b1; bus.req1_a = 32'h1; bus.req1_b = 32'h1; bus.req1_sub = 1'b0;
    #1;
    check("bp.exec_rdy", 64'({bus.req0_ready, bus.req1_ready}), 64'(0));
    tick();
    for (int i = 0; i < 5; i++) begin
      check("bp.valid", 64'(bus.rsp_valid), 64'(1));
      check("bp.sum",   64'(bus.rsp_sum),   64'h30);
      check("bp.id",    64'(bus.rsp_id),    64'(0));
      check("bp.rdy",   64'({bus.req0_ready, bus.req1_ready}), 64'(0));
      tick();
    end
    bus.rsp_ready = 1'b1;
    #1;
    check("bp.consume_rdy", 64'({bus.req0_ready, bus.req1_ready}), 64'(0));
    tick();
    check("bp.idle_valid", 64'(bus.rsp_valid), 64'(0));
    check("bp.sum_kept",   64'(bus.rsp_sum),   64'h30);
    check("bp.ready1",     64'(bus.req1_ready), 64'(1));
    tick();
    bus.req1_valid = 1'b0;
    tick();
    check("bp.r1_valid", 64'(bus.rsp_valid), 64'(1));
    check("bp.r1_sum",   64'(bus.rsp_sum),   64'h2);
    check("bp.r1_id",    64'(bus.rsp_id),    64'(1));
    tick();

    // Reset pulsed during EXEC discards the operation.
    bus.req0_valid = 1'b1; bus.req0_a = 32'h9; bus.req0_b = 32'h1; bus.req0_sub = 1'b0;
    #1;
    check("rx.ready0", 64'(bus.req0_ready), 64'(1));
    tick();
    bus.req0_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("rx.valid", 64'(bus.rsp_valid), 64'(0));
    check("rx.sum",   64'(bus.rsp_sum),   64'(0));
    check("rx.id",    64'(bus.rsp_id),    64'(0));
    check("rx.flags", 64'({bus.rsp_cout, bus.rsp_ovf}), 64'(0));
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("rx.no_rsp", 64'(bus.rsp_valid), 64'(0));
    bus.req0_valid = 1'b1; bus.req0_a = 32'h4;   bus.req0_b = 32'h4; bus.req0_sub = 1'b0;
    bus.req1_valid = 1'b1; bus.req1_a = 32'h100; bus.req1_b = 32'h0; bus.req1_sub = 1'b0;
    #1;
    check("rx.ready0", 64'(bus.req0_ready), 64'(1));
    check("rx.ready1", 64'(bus.req1_ready), 64'(0));
    tick();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    tick();
    check("rx.post_valid", 64'(bus.rsp_valid), 64'(1));
    check("rx.post_sum",   64'(bus.rsp_sum),   64'h8);
    check("rx.post_id",    64'(bus.rsp_id),    64'(0));
    tick();
    check("rx.post_done",  64'(bus.rsp_valid), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
